// File: rtl/obj_reporter_pkg.sv
// Shared widths, FSM state encoding and report record layout for the
// object reporter and its dividers.
package obj_reporter_pkg;

    localparam int LBL_WIDTH = 4;
    localparam int LOC_SIZE  = 8;
    localparam int MAX_LABEL = (1 << LBL_WIDTH) - 1;

    typedef enum logic [2:0] {
        RPT_IDLE = 3'd0,
        RPT_ADDR = 3'd1,
        RPT_READ = 3'd2,
        RPT_DIV  = 3'd3,
        RPT_OUT  = 3'd4,
        RPT_FIN  = 3'd5
    } rpt_state_e;

    typedef struct packed {
        logic [LBL_WIDTH-1:0] id;
        logic [LOC_SIZE-1:0]  area;
        logic [LOC_SIZE-1:0]  cx;
        logic [LOC_SIZE-1:0]  cy;
    } rpt_rec_t;

endpackage

// File: rtl/obj_reporter_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses
// W cycles after the start edge; the remainder is not exported.
module seq_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, done_q, done_d;
    logic [W:0]    step, diff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        // rem < divisor always holds, so diff[W] is a clean borrow flag
        step   = {rem_q, quo_q[W-1]};
        diff   = step - {1'b0, dvs_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = CW'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            quo_d = {quo_q[W-2:0], ~diff[W]};
            rem_d = diff[W] ? step[W-1:0] : diff[W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/obj_reporter.sv
// Walks labels 1..num_labels through the labeller's data table and emits one
// record (area, centroid) per live label over a valid/ready handshake.
module obj_reporter
    import obj_reporter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LBL_WIDTH-1:0] num_labels,
    output logic [LBL_WIDTH-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [LBL_WIDTH-1:0] rpt_id,
    output logic [LOC_SIZE-1:0]  rpt_area,
    output logic [LOC_SIZE-1:0]  rpt_cx,
    output logic [LOC_SIZE-1:0]  rpt_cy,
    output logic                 busy,
    output logic                 done
);

    rpt_state_e           state_q, state_d, adv_state;
    logic [LBL_WIDTH-1:0] obj_id_q, obj_id_d, nlab_q, nlab_d, adv_id;
    logic [LOC_SIZE-1:0]  area_q, area_d, qx, qy;
    rpt_rec_t             rpt_q, rpt_d;
    logic                 div_start, dx_done, dy_done, last_id;

    seq_divider #(.W(LOC_SIZE)) u_div_x (
        .clk(clk), .reset_n(reset_n), .start(div_start),
        .dividend(obj_x), .divisor(obj_area), .quotient(qx), .done(dx_done)
    );

    seq_divider #(.W(LOC_SIZE)) u_div_y (
        .clk(clk), .reset_n(reset_n), .start(div_start),
        .dividend(obj_y), .divisor(obj_area), .quotient(qy), .done(dy_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RPT_IDLE;
            obj_id_q <= '0;
            nlab_q   <= '0;
            area_q   <= '0;
            rpt_q    <= '0;
        end else begin
            state_q  <= state_d;
            obj_id_q <= obj_id_d;
            nlab_q   <= nlab_d;
            area_q   <= area_d;
            rpt_q    <= rpt_d;
        end
    end

    // Compare before incrementing so the id stops at MAX_LABEL instead of wrapping
    assign last_id   = (obj_id_q == nlab_q);
    assign adv_state = last_id ? RPT_FIN : RPT_ADDR;
    assign adv_id    = last_id ? obj_id_q : obj_id_q + LBL_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        obj_id_d = obj_id_q;
        nlab_d   = nlab_q;
        area_d   = area_q;
        rpt_d    = rpt_q;
        case (state_q)
            RPT_IDLE: if (start) begin
                nlab_d   = num_labels;
                obj_id_d = LBL_WIDTH'(1);
                state_d  = (num_labels == '0) ? RPT_FIN : RPT_ADDR;
            end
            RPT_ADDR: state_d = RPT_READ;
            RPT_READ: begin
                area_d = obj_area;
                if (obj_area == '0) begin
                    state_d  = adv_state;
                    obj_id_d = adv_id;
                end else begin
                    state_d = RPT_DIV;
                end
            end
            RPT_DIV: if (dx_done && dy_done) begin
                rpt_d   = '{id: obj_id_q, area: area_q, cx: qx, cy: qy};
                state_d = RPT_OUT;
            end
            RPT_OUT: if (rpt_ready) begin
                state_d  = adv_state;
                obj_id_d = adv_id;
            end
            RPT_FIN:  state_d = RPT_IDLE;
            default:  state_d = RPT_IDLE;
        endcase
    end

    always_comb begin
        rpt_valid = (state_q == RPT_OUT);
        busy      = (state_q != RPT_IDLE);
        done      = (state_q == RPT_FIN);
        div_start = (state_q == RPT_READ) && (obj_area != '0);
    end

    assign obj_id   = obj_id_q;
    assign rpt_id   = rpt_q.id;
    assign rpt_area = rpt_q.area;
    assign rpt_cx   = rpt_q.cx;
    assign rpt_cy   = rpt_q.cy;

endmodule

// File: tb/tb_obj_reporter.sv
// Randomized bench for obj_reporter: a synchronous table model feeds the DUT
// and a queue of expected records is built from the table with plain division.
module tb_obj_reporter;
    import obj_reporter_pkg::*;

    logic                 clk = 1'b0, reset_n = 1'b0, start = 1'b0, rpt_ready = 1'b0;
    logic [LBL_WIDTH-1:0] num_labels = '0, obj_id, rpt_id;
    logic [LOC_SIZE-1:0]  obj_area = '0, obj_x = '0, obj_y = '0;
    logic [LOC_SIZE-1:0]  rpt_area, rpt_cx, rpt_cy;
    logic                 rpt_valid, busy, done;

    logic [LOC_SIZE-1:0]  tbl_a [0:MAX_LABEL];
    logic [LOC_SIZE-1:0]  tbl_x [0:MAX_LABEL];
    logic [LOC_SIZE-1:0]  tbl_y [0:MAX_LABEL];

    typedef struct { int id; int area; int cx; int cy; } rec_t;
    rec_t exp_q[$];
    int   n_tests = 0, n_fail = 0;

    obj_reporter dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels),
        .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
        .rpt_area(rpt_area), .rpt_cx(rpt_cx), .rpt_cy(rpt_cy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        obj_area <= tbl_a[obj_id];
        obj_x    <= tbl_x[obj_id];
        obj_y    <= tbl_y[obj_id];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_obj_id"}, obj_id, 0);
        chk({pfx, "_valid"}, rpt_valid, 0);
        chk({pfx, "_rpt_id"}, rpt_id, 0);
        chk({pfx, "_area"}, rpt_area, 0);
        chk({pfx, "_cx"}, rpt_cx, 0);
        chk({pfx, "_cy"}, rpt_cy, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
    endtask

    task automatic fill(input int area_mode);
        for (int i = 0; i <= MAX_LABEL; i++) begin
            tbl_x[i] = LOC_SIZE'($urandom);
            tbl_y[i] = LOC_SIZE'($urandom);
            case (area_mode)
                0: tbl_a[i] = LOC_SIZE'($urandom_range(1, 255));
                1: tbl_a[i] = 1;
                default: tbl_a[i] = ($urandom % 4 == 0) ? '0 : LOC_SIZE'($urandom_range(1, 255));
            endcase
        end
    endtask

    // mode 0: ready always high; 1: random ready + stray starts; 2: stall 10 cycles
    task automatic run_pass(input int n, input int mode, input int abort_id);
        int   lat = 0, stall = 0, cyc = 0, dones = 0;
        bit   fin = 0, hold_v = 0, prev_valid = 0, wrap = 0;
        rec_t held, got, e;
        logic [LBL_WIDTH-1:0] prev_id;
        exp_q.delete();
        for (int id = 1; id <= n; id++)
            if (tbl_a[id] != 0) begin
                e.id = id; e.area = int'(tbl_a[id]);
                e.cx = int'(tbl_x[id]) / e.area; e.cy = int'(tbl_y[id]) / e.area;
                exp_q.push_back(e);
            end
        @(negedge clk);
        num_labels = LBL_WIDTH'(n);
        rpt_ready  = (mode == 0);
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        prev_id = obj_id;
        if (mode == 1) num_labels = LBL_WIDTH'($urandom);
        chk("busy_on_start", busy, 1);
        while (cyc < 3000 && !fin) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (obj_id != prev_id) lat = 0; else lat++;
            end
            prev_id = obj_id;
            if (busy && obj_id == 0) wrap = 1;
            if (abort_id != 0 && int'(obj_id) == abort_id && lat == 4) begin
                #2 reset_n = 1'b0;
                #1 chk_zero("rst_mid");
                @(negedge clk);
                chk("rst_no_done", done, 0);
                reset_n = 1'b1;
                return;
            end
            if (hold_v) begin
                chk("hold_valid", rpt_valid, 1);
                chk("hold_id", rpt_id, held.id);
                chk("hold_area", rpt_area, held.area);
                chk("hold_cx", rpt_cx, held.cx);
                chk("hold_cy", rpt_cy, held.cy);
            end
            if (mode == 0 && rpt_valid && !prev_valid) chk("latency", lat, 3 + LOC_SIZE);
            prev_valid = rpt_valid;
            if (mode == 1) rpt_ready = ($urandom % 2) == 1;
            else if (mode == 2) rpt_ready = (stall >= 10);
            got.id = rpt_id; got.area = rpt_area; got.cx = rpt_cx; got.cy = rpt_cy;
            if (rpt_valid && rpt_ready) begin
                if (exp_q.size() == 0) chk("extra_record", int'(rpt_id), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("rec_id", got.id, e.id);
                    chk("rec_area", got.area, e.area);
                    chk("rec_cx", got.cx, e.cx);
                    chk("rec_cy", got.cy, e.cy);
                end
            end
            hold_v = rpt_valid && !rpt_ready;
            if (hold_v) begin held = got; stall++; end
            if (done) begin
                dones++;
                fin = 1;
                if (n == 0) chk("n0_done_cycle", cyc, 0);
                if (mode == 1) start = 1'b1;
            end else if (mode == 1 && busy) begin
                start = ($urandom % 6) == 0;
            end
            cyc++;
        end
        chk("pass_finished", fin, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("records_left", exp_q.size(), 0);
        chk("done_count", dones, 1);
        chk("id_no_wrap", wrap, 0);
    endtask

    initial begin
        for (int i = 0; i <= MAX_LABEL; i++) begin
            tbl_a[i] = '0; tbl_x[i] = '0; tbl_y[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        tbl_a[1] = 4; tbl_x[1] = 10; tbl_y[1] = 22;
        run_pass(1, 0, 0);

        fill(0);
        tbl_a[2] = 0;
        run_pass(3, 0, 0);

        run_pass(0, 0, 0);

        fill(0);
        run_pass(1, 2, 0);

        fill(0);
        run_pass(3, 0, 2);
        run_pass(3, 0, 0);

        fill(1);
        run_pass(MAX_LABEL, 0, 0);

        for (int k = 0; k < 12; k++) begin
            fill(2);
            run_pass($urandom_range(0, MAX_LABEL), (k % 3 == 0) ? 0 : 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obj_reporter.md
OBJ_REPORTER -- requirements
Module: obj_reporter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle pulse requesting a report pass at frame end.
REQ-004 SHALL have port num_labels, input, `LBL_WIDTH, highest label allocated this frame, sampled on accepted start.
REQ-005 SHALL have port obj_id, output, `LBL_WIDTH, data-table read address driven to the labeller.
REQ-006 SHALL have ports obj_area / obj_x / obj_y, input, `LOC_SIZE each, table read data, valid one cycle after obj_id changes.
REQ-007 SHALL have port rpt_valid, output, 1, report record valid.
REQ-008 SHALL have port rpt_ready, input, 1, consumer accepts record.
REQ-009 SHALL have port rpt_id, output, `LBL_WIDTH, label of record.
REQ-010 SHALL have ports rpt_area / rpt_cx / rpt_cy, output, `LOC_SIZE each, area, centroid x = floor(obj_x/obj_area), centroid y = floor(obj_y/obj_area).
REQ-011 SHALL have port busy, output, 1, high from accepted start until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at end of pass.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, READ, DIV, OUT, FIN.
REQ-014 IDLE: on start, SHALL latch num_labels, set obj_id=1, go ADDR; if latched num_labels==0, SHALL go FIN directly.
REQ-015 ADDR: SHALL hold obj_id one cycle for the synchronous table read, then go READ.
REQ-016 READ: SHALL capture obj_area/obj_x/obj_y; area==0 (merged/unused label) SHALL skip to next-id logic without a record; else SHALL start both dividers and go DIV.
REQ-017 DIV: SHALL wait for both divider done flags (exactly `LOC_SIZE cycles after start), then load rpt_* registers and go OUT.
REQ-018 OUT: rpt_valid=1; rpt_* SHALL stay stable while rpt_valid && !rpt_ready; on rpt_valid && rpt_ready SHALL apply next-id logic.
REQ-019 Next-id: if obj_id == latched num_labels SHALL go FIN, else obj_id+1 and go ADDR; comparison precedes increment so obj_id never wraps at `MAX_LABEL.
REQ-020 FIN: done=1 for one cycle, busy=0 next cycle, return IDLE.
REQ-021 start while busy SHALL be ignored; a start coinciding with the FIN cycle SHALL be ignored.
REQ-022 Per-object latency from obj_id change to rpt_valid SHALL be 2 + `LOC_SIZE + 1 cycles with rpt_ready held high.
REQ-023 Division SHALL be unsigned, truncating; quotient width `LOC_SIZE; remainder discarded.
REQ-024 rpt_ready asserted when rpt_valid is low SHALL have no effect.

Reset
REQ-025 reset_n low SHALL force IDLE, obj_id=0, rpt_valid=0, rpt_id=0, rpt_area=0, rpt_cx=0, rpt_cy=0, busy=0, done=0, divider state cleared.
REQ-026 reset asserted mid-pass SHALL abort the pass without emitting done; first start after release begins a fresh pass from id 1.

Structure
REQ-027 `LBL_WIDTH, `LOC_SIZE, `MAX_LABEL SHALL come from shared global.vh; FSM state encoding SHALL be added to global.vh as `RPT_* constants.
REQ-028 SHALL instantiate two copies of sub-module seq_divider (restoring, one quotient bit per cycle, start/done handshake, same clk/reset_n).
REQ-029 Implementation SHALL be 120-400 lines total including seq_divider.

Verification
REQ-030 Bench: num_labels=1, table[1]={area 4, x 10, y 22}, rpt_ready=1, start -> one record id 1, area 4, cx 2, cy 5, then done pulse.
REQ-031 Bench: num_labels=3, table[2].area=0 -> records for ids 1 and 3 only, then done.
REQ-032 Bench: num_labels=0, start -> done one cycle after IDLE exit, no rpt_valid.
REQ-033 Bench: rpt_ready low 10 cycles during OUT -> rpt_* unchanged all 10 cycles, single record accepted.
REQ-034 Bench: reset_n low during DIV of id 2 -> all outputs 0 asynchronously, no done; new start reports from id 1.
REQ-035 Bench: num_labels=`MAX_LABEL, all areas 1 -> `MAX_LABEL records with cx=x, cy=y, obj_id never wraps to 0 before done.
